dz_rbuf: RTL
============

Name: dz_rbuf

Overview:
- DZ11 receive-side scanner and 64-character receive silo (RBUF).
- Scans the eight line UART receivers. Each character from an enabled line with a full receiver is moved into a FIFO, tagged with line number and error flags.
- Presents the FIFO head as the RBUF register and pops it on RBUF reads.
- Generates RDONE and silo-alarm (SA) status for the CSR and interrupt logic.

Parameters:
- SILO_DEPTH, 64, number of silo entries (power of two).
- SA_THRESH, 16, characters entered since last RBUF read that set SA.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- devRESET  in  1  device reset from UBA; acts as reset
- devLOBYTE  in  1  device low-byte strobe
- rbufREAD  in  1  RBUF read cycle active; held for several clocks
- uartRXFULL  in  8  per-line UART receiver holds a character
- uartRXDATA  in  64  per-line received byte; line n at [8n+7:8n]
- uartRXFRME  in  8  per-line framing error for held character
- uartRXPARE  in  8  per-line parity error for held character
- uartRXCLR  out  8  one-hot, one-cycle pulse acknowledging line's character
- csrCLR  in  1  controller clear; acts as reset
- csrMSE  in  1  master scan enable
- csrSAE  in  1  silo alarm enable
- lprRXON  in  8  per-line receiver enable from LPR
- rbufRDONE  out  1  silo not empty
- rbufSA  out  1  silo alarm
- regRBUF  out  16  RBUF register value

Behaviour:
- Reset condition is rst | devRESET | csrCLR. On reset:
  - silo empty; pointers 0; count 0
  - scan = 0; state SCAN
  - pending overrun = 0; SA counter = 0
  - outputs: uartRXCLR = 0, rbufRDONE = 0, rbufSA = 0, regRBUF = 0
- regRBUF layout:
  - [15] DVAL = silo not empty
  - [14] OVRN
  - [13] FERR
  - [12] PERR
  - [11] = 0
  - [10:8] line number
  - [7:0] data
  - When the silo is empty, regRBUF = 0. Otherwise it is combinational from the head entry with DVAL = 1.
- Scanner FSM:
  - SCAN:
    - If csrMSE = 0: hold; scan is unchanged.
    - Else if lprRXON[scan] & uartRXFULL[scan]: go to LOAD.
    - Else: scan <= scan + 1 (3-bit wrap 7 -> 0).
  - LOAD (one cycle):
    - Pulse uartRXCLR[scan].
    - If the silo is not full (count evaluated before any same-cycle pop): push {pendingOVRN, FERR[scan], PERR[scan], scan, data}, then clear pendingOVRN.
    - If the silo is full: discard the character and set pendingOVRN.
    - If SAE = 1 and a character was pushed: increment the SA counter, saturating at SA_THRESH.
    - Next state WAIT.
  - WAIT (one cycle, lets UART full flag drop): scan <= scan + 1; next state SCAN.
  - Net throughput is at most one character per three clocks.
- Pop:
  - Occurs on the trailing edge of a read: the first cycle with !(rbufREAD & devLOBYTE) after a cycle with (rbufREAD & devLOBYTE).
  - regRBUF stays stable for the entire read.
  - Exactly one pop per read cycle. A read of an empty silo pops nothing.
- Simultaneous push and pop: both take effect; count is unchanged. A full silo in LOAD still drops the character even if a pop occurs in the same cycle.
- SA:
  - rbufSA = csrSAE & (SA counter == SA_THRESH).
  - The SA counter clears on every read trailing edge.
  - csrSAE = 0 clears the SA counter.
- rbufRDONE = !empty; registered, updated the same cycle as the pointers.
- lprRXON dropping for a line mid-LOAD does not abort the load.
- csrMSE dropping in LOAD or WAIT completes the sequence, then holds in SCAN.
- Reset mid-read: the silo clears and no pop occurs afterwards.

Decomposition:
- Package dz_pkg holds:
  - typedef dz_rbuf_entry_t: ovrn, ferr, perr, line[2:0], data[7:0]
  - RBUF bit-position constants
  - scanner state enum {SCAN, LOAD, WAIT}
- Sub-module dz_silo: synchronous FIFO of dz_rbuf_entry_t, SILO_DEPTH deep.
  - Inputs: push, pop, clr.
  - Outputs: head, empty, full, count.
  - Pop on empty and push on full are ignored.

Test Plan:
- Line 3 enabled, RXFULL[3] with data 0x41 and FERR = 1, MSE = 1:
  - uartRXCLR = 8'b0000_1000 pulses exactly one cycle.
  - regRBUF = 16'hA341 (DVAL, FERR, line 3, 0x41); rbufRDONE = 1.
- Read cycle held 4 clocks with two entries queued:
  - regRBUF is constant during the read.
  - After the trailing edge, the second entry is at the head; after a second read, regRBUF = 0 and RDONE = 0.
- Fill 64 characters with no reads, then supply two more:
  - Both extra characters get an RXCLR pulse and are dropped.
  - After one pop, the next pushed character reads back with OVRN = 1 ([14] set); the following character has OVRN = 0.
- SAE = 1:
  - After 15 characters, SA = 0; the 16th sets SA = 1.
  - One RBUF read clears SA even though 15 characters remain.
- Lines 0 and 7 both full, MSE = 1:
  - Service order follows scan order from the current scan value and wraps 7 -> 0.
  - Lines with lprRXON = 0 are never acknowledged.
- Assert csrCLR while the silo holds 10 entries and the FSM is in LOAD:
  - Next cycle: RDONE = 0, regRBUF = 0, SA = 0, no RXCLR pulse, scan restarts at line 0.

Source files
------------

// File: rtl/dz_rbuf_pkg.sv
// Shared types for the DZ11 receive path: silo entry layout, RBUF bit
// positions and the receive scanner states.
package dz_pkg;

  localparam int unsigned DZ_LINES      = 8;
  localparam int unsigned DZ_SILO_DEPTH = 64;
  localparam int unsigned DZ_SA_THRESH  = 16;

  typedef struct packed {
    logic       ovrn;
    logic       ferr;
    logic       perr;
    logic [2:0] line;
    logic [7:0] data;
  } dz_rbuf_entry_t;

  localparam int RBUF_DVAL     = 15;
  localparam int RBUF_OVRN     = 14;
  localparam int RBUF_FERR     = 13;
  localparam int RBUF_PERR     = 12;
  localparam int RBUF_LINE_LSB = 8;
  localparam int RBUF_DATA_LSB = 0;

  typedef enum logic [1:0] {
    SCAN,
    LOAD,
    WAIT
  } dz_scan_state_t;

  // Bit 11 is reserved and always reads zero.
  function automatic logic [15:0] dz_rbuf_pack(input dz_rbuf_entry_t e);
    logic [15:0] r;
    r                       = '0;
    r[RBUF_DVAL]            = 1'b1;
    r[RBUF_OVRN]            = e.ovrn;
    r[RBUF_FERR]            = e.ferr;
    r[RBUF_PERR]            = e.perr;
    r[RBUF_LINE_LSB +: 3]   = e.line;
    r[RBUF_DATA_LSB +: 8]   = e.data;
    return r;
  endfunction

endpackage

// File: rtl/dz_rbuf_if.sv
// Signal bundle between the DZ11 receive block and its surroundings
// (UBA bus, the eight UARTs, CSR and LPR).
interface dz_rbuf_if;

  logic        devRESET;
  logic        devLOBYTE;
  logic        rbufREAD;
  logic [7:0]  uartRXFULL;
  logic [63:0] uartRXDATA;
  logic [7:0]  uartRXFRME;
  logic [7:0]  uartRXPARE;
  logic [7:0]  uartRXCLR;
  logic        csrCLR;
  logic        csrMSE;
  logic        csrSAE;
  logic [7:0]  lprRXON;
  logic        rbufRDONE;
  logic        rbufSA;
  logic [15:0] regRBUF;

  modport master (
    output devRESET, devLOBYTE, rbufREAD,
    output uartRXFULL, uartRXDATA, uartRXFRME, uartRXPARE,
    output csrCLR, csrMSE, csrSAE, lprRXON,
    input  uartRXCLR, rbufRDONE, rbufSA, regRBUF
  );

  modport slave (
    input  devRESET, devLOBYTE, rbufREAD,
    input  uartRXFULL, uartRXDATA, uartRXFRME, uartRXPARE,
    input  csrCLR, csrMSE, csrSAE, lprRXON,
    output uartRXCLR, rbufRDONE, rbufSA, regRBUF
  );

endinterface

// File: rtl/dz_rbuf_silo.sv
// Receive silo: synchronous FIFO of RBUF entries. Pushes into a full silo
// and pops from an empty one are ignored.
module dz_silo
  import dz_pkg::*;
#(
  parameter int unsigned DEPTH = DZ_SILO_DEPTH
) (
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  dz_rbuf_entry_t         din_i,
  output dz_rbuf_entry_t         head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  dz_rbuf_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dz_rbuf.sv
// DZ11 receive scanner and silo: moves characters from enabled UART lines
// into the silo and presents the head as RBUF, with RDONE and silo alarm.
module dz_rbuf
  import dz_pkg::*;
#(
  parameter int unsigned SILO_DEPTH = DZ_SILO_DEPTH,
  parameter int unsigned SA_THRESH  = DZ_SA_THRESH
) (
  input logic      clk,
  input logic      rst,
  dz_rbuf_if.slave bus
);

  localparam int unsigned CW = $clog2(SILO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(SA_THRESH + 1);
  localparam logic [SW-1:0] SA_MAX = SW'(SA_THRESH);

  logic clr;
  assign clr = rst | bus.devRESET | bus.csrCLR;

  dz_scan_state_t state_q, state_d;
  logic [2:0]     scan_q, scan_d;
  logic           povrn_q, povrn_d;
  logic [SW-1:0]  sa_cnt_q, sa_cnt_d;
  logic           rd_act_q;

  logic           rd_act, pop, push;
  logic [7:0]     rxclr;
  dz_rbuf_entry_t din, head;
  logic           silo_empty, silo_full;
  logic [CW-1:0]  silo_level_unused;

  // A read pops on its trailing edge so RBUF stays stable while it is held.
  assign rd_act = bus.rbufREAD & bus.devLOBYTE;
  assign pop    = rd_act_q & ~rd_act;

  assign din = '{
    ovrn: povrn_q,
    ferr: bus.uartRXFRME[scan_q],
    perr: bus.uartRXPARE[scan_q],
    line: scan_q,
    data: bus.uartRXDATA[{scan_q, 3'b000} +: 8]
  };

  dz_silo #(.DEPTH(SILO_DEPTH)) u_silo (
    .clk     (clk),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .empty_o (silo_empty),
    .full_o  (silo_full),
    .count_o (silo_level_unused)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    povrn_d = povrn_q;
    push    = 1'b0;
    rxclr   = '0;
    unique case (state_q)
      SCAN: begin
        if (bus.csrMSE) begin
          if (bus.lprRXON[scan_q] & bus.uartRXFULL[scan_q]) state_d = LOAD;
          else                                               scan_d  = scan_q + 3'd1;
        end
      end
      LOAD: begin
        // Fullness is taken before any same-cycle pop, so a full silo drops.
        rxclr[scan_q] = 1'b1;
        if (silo_full) begin
          povrn_d = 1'b1;
        end else begin
          push    = 1'b1;
          povrn_d = 1'b0;
        end
        state_d = WAIT;
      end
      WAIT: begin
        scan_d  = scan_q + 3'd1;
        state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    sa_cnt_d = sa_cnt_q;
    if (!bus.csrSAE || pop)                sa_cnt_d = '0;
    else if (push && (sa_cnt_q != SA_MAX)) sa_cnt_d = sa_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= SCAN;
      scan_q   <= '0;
      povrn_q  <= 1'b0;
      sa_cnt_q <= '0;
      rd_act_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      scan_q   <= scan_d;
      povrn_q  <= povrn_d;
      sa_cnt_q <= sa_cnt_d;
      rd_act_q <= rd_act;
    end
  end

  assign bus.uartRXCLR = rxclr;
  assign bus.rbufRDONE = ~silo_empty;
  assign bus.rbufSA    = bus.csrSAE & (sa_cnt_q == SA_MAX);
  assign bus.regRBUF   = silo_empty ? 16'h0000 : dz_rbuf_pack(head);

endmodule
